// File: rtl/cpu_pkg.sv
// Shared CPU constants: default widths, opcode map and execute-stage state encoding.
// Used by the execute unit, register file and decoder.
package cpu_pkg;

   localparam int unsigned DATA_WIDTH_DEF  = 8;
   localparam int unsigned REG_BIT_CNT_DEF = 3;
   localparam int unsigned OPC_WIDTH_DEF   = 4;

   localparam int unsigned OP_NOP = 0;
   localparam int unsigned OP_LDR = 1;
   localparam int unsigned OP_STR = 2;
   localparam int unsigned OP_ADD = 3;
   localparam int unsigned OP_SUB = 4;
   localparam int unsigned OP_AND = 5;
   localparam int unsigned OP_OR  = 6;
   localparam int unsigned OP_XOR = 7;
   localparam int unsigned OP_MUL = 8;
   localparam int unsigned OP_LDI = 9;
   localparam int unsigned OP_SHL = 10;
   localparam int unsigned OP_SHR = 11;

   typedef enum logic [1:0] {
      StIdle,
      StExec,
      StMul
   } state_e;

endpackage

// File: rtl/shift_add_mul.sv
// Iterative shift-add multiplier: WIDTH iterations after a start pulse.
// done and product are asserted/valid combinationally during the last iteration.
module shift_add_mul #(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic [2*WIDTH-1:0] step;
   logic               last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         prod_q   <= prod_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
      end
   end

   always_comb begin
      step     = prod_q + (mplier_q[0] ? mcand_q : '0);
      last     = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      prod_d   = prod_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      if (start) begin
         mcand_d  = {{WIDTH{1'b0}}, multiplicand};
         mplier_d = multiplier;
         prod_d   = '0;
         cnt_d    = '0;
         busy_d   = 1'b1;
      end else if (busy_q) begin
         prod_d   = step;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + CNT_W'(1);
         if (last) begin
            busy_d = 1'b0;
         end
      end
   end

   assign done    = last;
   assign product = step;

endmodule

// File: rtl/acc_exec_unit.sv
// Accumulator execute stage: latches one instruction per handshake, runs single-cycle
// ALU ops in EXEC and hands MUL to the iterative multiplier.
module acc_exec_unit
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int unsigned REG_BIT_CNT = REG_BIT_CNT_DEF,
   parameter int unsigned OPC_WIDTH   = OPC_WIDTH_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   instr_valid,
   output logic                   instr_ready,
   input  logic [OPC_WIDTH-1:0]   opcode,
   input  logic [REG_BIT_CNT-1:0] operand_reg,
   input  logic [DATA_WIDTH-1:0]  imm,
   input  logic [DATA_WIDTH-1:0]  rf_data,
   output logic [REG_BIT_CNT-1:0] rf_sel,
   output logic                   rf_we,
   output logic [DATA_WIDTH-1:0]  acc,
   output logic                   flag_z,
   output logic                   flag_c,
   output logic                   illegal
);

   state_e                 state_q, state_d;
   logic [OPC_WIDTH-1:0]   opc_q, opc_d;
   logic [REG_BIT_CNT-1:0] reg_q, reg_d;
   logic [DATA_WIDTH-1:0]  imm_q, imm_d;
   logic [DATA_WIDTH-1:0]  acc_q, acc_d;
   logic                   z_q, z_d;
   logic                   c_q, c_d;

   logic                    accept;
   logic                    mul_start;
   logic                    mul_done;
   logic [2*DATA_WIDTH-1:0] mul_product;
   logic [DATA_WIDTH:0]     sum;
   logic [DATA_WIDTH:0]     diff;

   assign accept = instr_valid && instr_ready;

   shift_add_mul #(
      .WIDTH(DATA_WIDTH)
   ) u_mul (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (mul_start),
      .multiplicand(acc_q),
      .multiplier  (rf_data),
      .done        (mul_done),
      .product     (mul_product)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (accept) state_d = StExec;
         StExec: state_d = (opc_q == OPC_WIDTH'(OP_MUL)) ? StMul : StIdle;
         StMul:  if (mul_done) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      instr_ready = (state_q == StIdle);
      rf_we       = (state_q == StExec) && (opc_q == OPC_WIDTH'(OP_STR));
      mul_start   = (state_q == StExec) && (opc_q == OPC_WIDTH'(OP_MUL));
      illegal     = (state_q == StExec) && (opc_q > OPC_WIDTH'(OP_SHR));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opc_q <= '0;
         reg_q <= '0;
         imm_q <= '0;
         acc_q <= '0;
         z_q   <= 1'b0;
         c_q   <= 1'b0;
      end else begin
         opc_q <= opc_d;
         reg_q <= reg_d;
         imm_q <= imm_d;
         acc_q <= acc_d;
         z_q   <= z_d;
         c_q   <= c_d;
      end
   end

   // Carry and borrow both come out of bit DATA_WIDTH of a zero-extended add/sub.
   assign sum  = {1'b0, acc_q} + {1'b0, rf_data};
   assign diff = {1'b0, acc_q} - {1'b0, rf_data};

   always_comb begin
      opc_d = opc_q;
      reg_d = reg_q;
      imm_d = imm_q;
      acc_d = acc_q;
      z_d   = z_q;
      c_d   = c_q;
      if (accept) begin
         opc_d = opcode;
         reg_d = operand_reg;
         imm_d = imm;
      end
      if (state_q == StExec) begin
         unique case (opc_q)
            OPC_WIDTH'(OP_LDR): acc_d = rf_data;
            OPC_WIDTH'(OP_ADD): {c_d, acc_d} = sum;
            OPC_WIDTH'(OP_SUB): {c_d, acc_d} = diff;
            OPC_WIDTH'(OP_AND): acc_d = acc_q & rf_data;
            OPC_WIDTH'(OP_OR):  acc_d = acc_q | rf_data;
            OPC_WIDTH'(OP_XOR): acc_d = acc_q ^ rf_data;
            OPC_WIDTH'(OP_LDI): acc_d = imm_q;
            OPC_WIDTH'(OP_SHL): {c_d, acc_d} = {acc_q, 1'b0};
            OPC_WIDTH'(OP_SHR): {acc_d, c_d} = {1'b0, acc_q};
            default: ;
         endcase
         // NOP, STR, MUL setup and undefined opcodes leave the flags alone.
         if (opc_q != OPC_WIDTH'(OP_NOP) && opc_q != OPC_WIDTH'(OP_STR)
             && opc_q != OPC_WIDTH'(OP_MUL) && opc_q <= OPC_WIDTH'(OP_SHR)) begin
            z_d = (acc_d == '0);
         end
      end else if (state_q == StMul && mul_done) begin
         acc_d = mul_product[DATA_WIDTH-1:0];
         c_d   = |mul_product[2*DATA_WIDTH-1:DATA_WIDTH];
         z_d   = (mul_product[DATA_WIDTH-1:0] == '0);
      end
   end

   assign rf_sel = reg_q;
   assign acc    = acc_q;
   assign flag_z = z_q;
   assign flag_c = c_q;

endmodule

// File: tb/tb_acc_exec_unit.sv
// Directed bench for acc_exec_unit with a behavioural register file around it.
module tb_acc_exec_unit;

   localparam int LIMIT = 100;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       instr_valid = 1'b0;
   logic       instr_ready;
   logic [3:0] opcode = '0;
   logic [2:0] operand_reg = '0;
   logic [7:0] imm = '0;
   logic [7:0] rf_data;
   logic [2:0] rf_sel;
   logic       rf_we;
   logic [7:0] acc;
   logic       flag_z;
   logic       flag_c;
   logic       illegal;

   logic [7:0] rf [8];
   int         n_tests = 0;
   int         n_fail = 0;
   int         we_cnt = 0;
   int         ill_cnt = 0;
   logic [2:0] we_sel = '0;
   int         cyc;

   acc_exec_unit u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .opcode     (opcode),
      .operand_reg(operand_reg),
      .imm        (imm),
      .rf_data    (rf_data),
      .rf_sel     (rf_sel),
      .rf_we      (rf_we),
      .acc        (acc),
      .flag_z     (flag_z),
      .flag_c     (flag_c),
      .illegal    (illegal)
   );

   always #5 clk = ~clk;

   assign rf_data = rf[rf_sel];

   always @(posedge clk) begin
      if (rf_we) rf[rf_sel] <= acc;
   end

   always @(negedge clk) begin
      if (rf_we) begin
         we_cnt <= we_cnt + 1;
         we_sel <= rf_sel;
      end
      if (illegal) ill_cnt <= ill_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic [3:0] op, input logic [2:0] r, input logic [7:0] im);
      int n = 0;
      opcode      = op;
      operand_reg = r;
      imm         = im;
      instr_valid = 1'b1;
      while (!instr_ready && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      check("issue_ready", 32'(instr_ready), 1);
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
   endtask

   // Counts negedges with instr_ready low; returns at the first negedge it is high.
   task automatic wait_idle(output int busy);
      busy = 0;
      @(negedge clk);
      while (!instr_ready && busy < LIMIT) begin
         busy++;
         @(negedge clk);
      end
      check("idle_ready", 32'(instr_ready), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 8; i++) rf[i] = 8'h00;
      rf[1] = 8'h81;
      rf[2] = 8'h07;
      rf[4] = 8'h0B;

      repeat (2) @(negedge clk);
      check("rst_acc", 32'(acc), 0);
      check("rst_z", 32'(flag_z), 0);
      check("rst_c", 32'(flag_c), 0);
      check("rst_ready", 32'(instr_ready), 1);
      check("rst_we", 32'(rf_we), 0);
      check("rst_sel", 32'(rf_sel), 0);
      rst_n = 1'b1;

      // Reset in the middle of a multiply.
      issue(4'd9, 3'd0, 8'h0C);
      wait_idle(cyc);
      issue(4'd8, 3'd4, 8'h00);
      repeat (3) @(negedge clk);
      check("mulrst_busy", 32'(instr_ready), 0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("mulrst_acc", 32'(acc), 0);
      check("mulrst_z", 32'(flag_z), 0);
      check("mulrst_c", 32'(flag_c), 0);
      check("mulrst_we", 32'(rf_we), 0);
      check("mulrst_ready", 32'(instr_ready), 1);

      // ADD with carry out and zero result; acc not yet updated during EXEC.
      issue(4'd9, 3'd0, 8'h7F);
      wait_idle(cyc);
      issue(4'd3, 3'd1, 8'h00);
      check("add_exec_acc", 32'(acc), 32'h7F);
      wait_idle(cyc);
      check("add_lat", 32'(cyc), 1);
      check("add_acc", 32'(acc), 32'h00);
      check("add_c", 32'(flag_c), 1);
      check("add_z", 32'(flag_z), 1);

      // SUB with borrow, then STR and back-to-back LDR of the same register.
      issue(4'd9, 3'd0, 8'h05);
      wait_idle(cyc);
      issue(4'd4, 3'd2, 8'h00);
      wait_idle(cyc);
      check("sub_acc", 32'(acc), 32'hFE);
      check("sub_c", 32'(flag_c), 1);
      check("sub_z", 32'(flag_z), 0);
      we_cnt = 0;
      issue(4'd2, 3'd3, 8'h00);
      wait_idle(cyc);
      check("str_we_cnt", 32'(we_cnt), 1);
      check("str_sel", 32'(we_sel), 3);
      check("str_rf3", 32'(rf[3]), 32'hFE);
      check("str_acc", 32'(acc), 32'hFE);
      issue(4'd9, 3'd0, 8'h11);
      wait_idle(cyc);
      issue(4'd1, 3'd3, 8'h00);
      wait_idle(cyc);
      check("ldr_acc", 32'(acc), 32'hFE);
      check("ldr_z", 32'(flag_z), 0);

      // Multiply 0x0C * 0x0B = 0x84.
      issue(4'd9, 3'd0, 8'h0C);
      wait_idle(cyc);
      issue(4'd8, 3'd4, 8'h00);
      wait_idle(cyc);
      check("mul1_lat", 32'(cyc), 9);
      check("mul1_acc", 32'(acc), 32'h84);
      check("mul1_c", 32'(flag_c), 0);
      check("mul1_z", 32'(flag_z), 0);

      // Multiply 0x20 * 0x10 = 0x200: low half zero, high half nonzero.
      rf[4] = 8'h10;
      issue(4'd9, 3'd0, 8'h20);
      wait_idle(cyc);
      issue(4'd8, 3'd4, 8'h00);
      wait_idle(cyc);
      check("mul2_acc", 32'(acc), 32'h00);
      check("mul2_c", 32'(flag_c), 1);
      check("mul2_z", 32'(flag_z), 1);

      // Undefined opcode: one illegal pulse, state untouched.
      issue(4'd9, 3'd0, 8'h55);
      wait_idle(cyc);
      ill_cnt = 0;
      issue(4'd13, 3'd0, 8'hAA);
      wait_idle(cyc);
      check("ill_cnt", 32'(ill_cnt), 1);
      check("ill_acc", 32'(acc), 32'h55);
      check("ill_c", 32'(flag_c), 1);
      check("ill_z", 32'(flag_z), 0);

      // instr_valid held high across a busy multiply.
      issue(4'd9, 3'd0, 8'h0C);
      wait_idle(cyc);
      issue(4'd8, 3'd4, 8'h00);
      opcode      = 4'd9;
      imm         = 8'h3C;
      instr_valid = 1'b1;
      wait_idle(cyc);
      check("hold_lat", 32'(cyc), 9);
      check("hold_mul_acc", 32'(acc), 32'hC0);
      check("hold_mul_c", 32'(flag_c), 0);
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      wait_idle(cyc);
      check("hold_ldi_acc", 32'(acc), 32'h3C);

      // Shifts.
      issue(4'd9, 3'd0, 8'h81);
      wait_idle(cyc);
      issue(4'd10, 3'd0, 8'h00);
      wait_idle(cyc);
      check("shl_acc", 32'(acc), 32'h02);
      check("shl_c", 32'(flag_c), 1);
      issue(4'd11, 3'd0, 8'h00);
      wait_idle(cyc);
      check("shr_acc", 32'(acc), 32'h01);
      check("shr_c", 32'(flag_c), 0);
      check("shr_z", 32'(flag_z), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
